id_stage_pipe: RTL
==================

# id_stage_pipe

Registered RV32I decode stage with a valid/ready handshake, parametrised operand forwarding, load-use stall detection and early JAL redirect. It sits between the fetch buffer and the execute stage. It reads the register file asynchronously through ra1/ra2, resolves operands against NFWD forwarding sources, and presents one decoded bundle per accepted instruction on a pipeline register.

## Interface
- NFWD, 2, number of forwarding sources (1..4); slot 0 is the youngest and has the highest priority.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  kill the output register and any instruction accepted this cycle.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage accepts the bundle this cycle.
- in_pc  in  32  instruction PC.
- in_is  in  32  instruction word.
- in_ppc  in  32  fetch-predicted next PC.
- re1, re2  out  1  register-file read enables.
- ra1, ra2  out  5  read addresses: in_is[19:15] and in_is[24:20].
- rn1, rn2  in  32  register-file read data, combinational.
- fwd_we  in  NFWD  slot write-enable.
- fwd_wa  in  5*NFWD  slot write address; slot k occupies bits [5k+4:5k].
- fwd_wn  in  32*NFWD  slot write data.
- fwd_ld  in  NFWD  slot is a load whose data is not yet available.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_t, out_st, out_sst  out  7/3/1  opcode, funct3, is[30].
- out_op1, out_op2, out_imm  out  32  operands and the store/branch offset.
- out_wa, out_we  out  5/1  destination register and write enable.
- out_pc, out_ppc, out_npc  out  32  PC, predicted PC, computed target.
- out_ill  out  1  unknown opcode.
- redir_valid, redir_pc  out  1/32  early JAL redirect to fetch.

## Operation
- Accept condition: in_valid && in_ready. in_ready = (!out_valid || out_ready) && !stall.
- Operand forwarding, for each source with re=1 and rs!=0:
  - Scan slots 0..NFWD-1. The first slot with fwd_we && fwd_wa==rs wins.
  - If the winning slot has fwd_ld set, assert stall. Otherwise take its fwd_wn.
  - If no slot matches, use rn. rs==0 yields 0 and never stalls.
- Decode per opcode (op1 / op2 / out_imm / we / re1,re2 / out_npc):
  - LUI 0110111: U-imm / U-imm / 0 / 1 / 0,0.
  - AUIPC 0010111: pc+U-imm / pc / 0 / 1 / 0,0.
  - OP 0110011: rs1 / rs2 / 0 / 1 / 1,1.
  - OP-IMM 0010011: rs1 / imm / 0 / 1 / 1,0.
    - imm is the sign-extended I-imm.
    - For funct3 001 and 101, imm is {27'b0, is[24:20]}.
  - LOAD 0000011: rs1 / I-imm / 0 / 1 / 1,0.
  - STORE 0100011: rs1 / rs2 / S-imm / 0 / 1,1.
  - BRANCH 1100011: rs1 / rs2 / B-imm / 0 / 1,1. out_npc = pc+B-imm.
  - JAL 1101111: pc+4 / pc+4 / 0 / 1 / 0,0. out_npc = pc+J-imm.
  - JALR 1100111: rs1 / pc+4 / I-imm / 1 / 1,0. out_npc = (rs1+I-imm) & ~1, using the forwarded rs1.
  - Other opcodes: op1/op2/imm = 0, we=0, re=0, out_ill=1.
- out_we is forced to 0 when rd==0.
- in_is==0 is a bubble: it is accepted and out_valid is not set.
- Redirect: on accept of a JAL whose target differs from in_ppc, set redir_valid=1 and redir_pc=target.
- Output register update priority per cycle:
  - rst: all outputs 0.
  - Else flush: out_valid=0 and redir_valid=0. An input accepted this cycle is discarded.
  - Else accept of a non-bubble: load the bundle and set out_valid=1.
  - Else out_ready: out_valid=0.
  - Else hold.
- Stall with the output register draining: out_valid falls to 0 and the input is held upstream.

## Timing
- Accept-to-out_valid latency: 1 cycle. Full throughput of 1 instruction per cycle when out_ready stays high.
- redir_valid is a 1-cycle pulse, registered, and coincides with out_valid of its JAL.
- Output data is stable while out_valid && !out_ready.
- in_ready, re1/re2, ra1/ra2 and stall are combinational from the current inputs and out_valid/out_ready.
- Reset value of every registered output is 0, including out_valid, redir_valid and out_ill.
- Flush in the same cycle as an accept: the instruction is lost and out_valid=0 next cycle.
- Flush with rst: rst wins. All outputs are 0.
- Stall and flush together: in_ready=0 and out_valid is cleared.

## Test plan
- LUI then dependent ADDI:
  - Stimulus: 0x123450B7 (x1=0x12345000), then addi x2,x1,1 with slot0 we=1, wa=1, wn=0x12345000.
  - Required: out_op1=0x12345000, out_op2=1, out_wa=2.
- Load-use stall:
  - Stimulus: slot0 we=1, ld=1, wa=5; add x6,x5,x7 offered.
  - Required: in_ready=0 while ld=1. After ld drops with wn=0xAA, the instruction is accepted with out_op1=0xAA.
- JAL early redirect:
  - Stimulus: pc=0x100, jal x1,+0x20, in_ppc=0x104.
  - Required: next cycle out_op1=0x104, out_npc=0x120, redir_valid=1, redir_pc=0x120.
  - With in_ppc=0x120, redir_valid stays 0.
- Back-pressure:
  - Stimulus: out_ready=0 for 3 cycles with 2 valid bundles offered.
  - Required: the first bundle is held unchanged, in_ready=0, and the second is accepted in the cycle out_ready rises.
- Flush and reset:
  - Stimulus: flush asserted while accepting a BEQ with out_valid=1.
  - Required: out_valid=0 next cycle.
  - Stimulus: rst asserted mid-stream.
  - Required: every output is 0 on the next edge.
- Priority and x0:
  - Stimulus: slots 0 and 1 both target x3 with wn 0x11 and 0x22.
  - Required: operand = 0x11.
  - Stimulus: source x0 with a matching slot that has ld=1.
  - Required: operand = 0 and no stall.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered RV32I decode stage with forwarding, load-use stall and early JAL redirect
// Inputs: fetch bundle (in_valid/in_pc/in_is/in_ppc), register-file read data (rn1/rn2),
//         NFWD forwarding slots (fwd_we/fwd_wa/fwd_wn/fwd_ld), execute back-pressure (out_ready), flush.
// Outputs: in_ready, register-file reads (re1/re2/ra1/ra2), registered decoded bundle (out_*),
//          and a registered one-cycle JAL redirect (redir_valid/redir_pc).
module id_stage_pipe #(
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_is,
    input  logic [31:0]          in_ppc,
    output logic                 re1,
    output logic                 re2,
    output logic [4:0]           ra1,
    output logic [4:0]           ra2,
    input  logic [31:0]          rn1,
    input  logic [31:0]          rn2,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [5*NFWD-1:0]    fwd_wa,
    input  logic [32*NFWD-1:0]   fwd_wn,
    input  logic [NFWD-1:0]      fwd_ld,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           out_t,
    output logic [2:0]           out_st,
    output logic                 out_sst,
    output logic [31:0]          out_op1,
    output logic [31:0]          out_op2,
    output logic [31:0]          out_imm,
    output logic [4:0]           out_wa,
    output logic                 out_we,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_ppc,
    output logic [31:0]          out_npc,
    output logic                 out_ill,
    output logic                 redir_valid,
    output logic [31:0]          redir_pc
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_OP = 7'b0110011,
                           OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    // Returns {pending_load, value}; slots scanned oldest-first so slot 0 overrides last.
    function automatic logic [32:0] resolve(input logic [4:0] rs, input logic [31:0] rn,
                                            input logic [NFWD-1:0] we, input logic [5*NFWD-1:0] wa,
                                            input logic [32*NFWD-1:0] wn, input logic [NFWD-1:0] ld);
        logic [32:0] r;
        r = {1'b0, rn};
        for (int k = NFWD - 1; k >= 0; k--)
            if (we[k] && wa[5*k +: 5] == rs) r = {ld[k], wn[32*k +: 32]};
        return rs == 5'd0 ? 33'd0 : r;
    endfunction
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rd;
    logic [31:0] w_i, w_s, w_b, w_u, w_j, w_pc4;
    logic [32:0] w_f1, w_f2;
    logic [31:0] w_op1, w_op2, w_imm, w_npc;
    logic        w_we, w_ill, w_stall, w_acc, w_redir;
    assign w_opc = in_is[6:0];
    assign w_f3  = in_is[14:12];
    assign w_rd  = in_is[11:7];
    assign ra1   = in_is[19:15];
    assign ra2   = in_is[24:20];
    assign w_i   = {{20{in_is[31]}}, in_is[31:20]};
    assign w_s   = {{20{in_is[31]}}, in_is[31:25], in_is[11:7]};
    assign w_b   = {{19{in_is[31]}}, in_is[31], in_is[7], in_is[30:25], in_is[11:8], 1'b0};
    assign w_u   = {in_is[31:12], 12'd0};
    assign w_j   = {{11{in_is[31]}}, in_is[31], in_is[19:12], in_is[20], in_is[30:21], 1'b0};
    assign w_pc4 = in_pc + 32'd4;
    assign w_f1  = resolve(ra1, rn1, fwd_we, fwd_wa, fwd_wn, fwd_ld);
    assign w_f2  = resolve(ra2, rn2, fwd_we, fwd_wa, fwd_wn, fwd_ld);
    assign w_stall = (re1 && w_f1[32]) || (re2 && w_f2[32]);
    assign in_ready = (!out_valid || out_ready) && !w_stall;
    assign w_acc = in_valid && in_ready;
    assign w_redir = w_opc == OP_JAL && w_npc != in_ppc;
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        w_imm = '0;
        w_we  = 1'b0;
        w_ill = 1'b0;
        re1   = 1'b0;
        re2   = 1'b0;
        w_npc = w_pc4;
        case (w_opc)
            OP_LUI:   begin w_op1 = w_u; w_op2 = w_u; w_we = 1'b1; end
            OP_AUIPC: begin w_op1 = in_pc + w_u; w_op2 = in_pc; w_we = 1'b1; end
            OP_OP:    begin w_op1 = w_f1[31:0]; w_op2 = w_f2[31:0]; w_we = 1'b1; re1 = 1'b1; re2 = 1'b1; end
            OP_IMM: begin
                w_op1 = w_f1[31:0];
                // Shift-immediates carry a bare 5-bit shamt, not a sign-extended immediate.
                w_op2 = (w_f3 == 3'b001 || w_f3 == 3'b101) ? {27'd0, in_is[24:20]} : w_i;
                w_we  = 1'b1;
                re1   = 1'b1;
            end
            OP_LOAD:  begin w_op1 = w_f1[31:0]; w_op2 = w_i; w_we = 1'b1; re1 = 1'b1; end
            OP_STORE: begin w_op1 = w_f1[31:0]; w_op2 = w_f2[31:0]; w_imm = w_s; re1 = 1'b1; re2 = 1'b1; end
            OP_BR: begin
                w_op1 = w_f1[31:0];
                w_op2 = w_f2[31:0];
                w_imm = w_b;
                re1   = 1'b1;
                re2   = 1'b1;
                w_npc = in_pc + w_b;
            end
            OP_JAL:   begin w_op1 = w_pc4; w_op2 = w_pc4; w_we = 1'b1; w_npc = in_pc + w_j; end
            OP_JALR: begin
                w_op1 = w_f1[31:0];
                w_op2 = w_pc4;
                w_imm = w_i;
                w_we  = 1'b1;
                re1   = 1'b1;
                w_npc = (w_f1[31:0] + w_i) & ~32'd1;
            end
            default:  w_ill = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_t       <= '0;
            out_st      <= '0;
            out_sst     <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_wa      <= '0;
            out_we      <= 1'b0;
            out_pc      <= '0;
            out_ppc     <= '0;
            out_npc     <= '0;
            out_ill     <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            redir_valid <= 1'b0;
        end else if (w_acc && in_is != 32'd0) begin
            out_valid   <= 1'b1;
            out_t       <= w_opc;
            out_st      <= w_f3;
            out_sst     <= in_is[30];
            out_op1     <= w_op1;
            out_op2     <= w_op2;
            out_imm     <= w_imm;
            out_wa      <= w_rd;
            out_we      <= w_we && w_rd != 5'd0;
            out_pc      <= in_pc;
            out_ppc     <= in_ppc;
            out_npc     <= w_npc;
            out_ill     <= w_ill;
            redir_valid <= w_redir;
            redir_pc    <= w_npc;
        end else begin
            out_valid   <= out_valid && !out_ready;
            redir_valid <= 1'b0;
        end
    end
endmodule
